// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 32'd8;
  localparam int DEFAULT_DEPTH  = 32'd8;

  // Smallest w such that 2**w >= value; used to size pointers and counters.
  function automatic int clog2(input int value);
    int w;
    w = 32'd0;
    while ((32'd1 << w) < value) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port and one registered read port, no reset on contents.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port: store incoming word at the write address.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: capture the addressed word; a same-cycle write to this slot
  // is seen only on a later read (old data is returned).
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: pointers, occupancy, status and sticky
// error flags; storage lives in fifo_mem.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 32'sd2,
  parameter int AE_LEVEL = 32'sd2
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq,
  input  logic [DATA_W-1:0]      din,
  input  logic                   deq,
  output logic [DATA_W-1:0]      dout,
  output logic                   dout_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 32'sd1;

  // Parameter sanity: power-of-two depth keeps pointer wrap free, and the
  // thresholds must be ordered inside the FIFO range.
  if ((DEPTH < 32'sd2) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("param_fifo: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_dout_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_rd_data;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});

  // Accept decisions: flush swallows both requests; a write into a full FIFO
  // is allowed only when a read frees a slot in the same cycle.
  always_comb begin
    w_rd_ok = 1'b0;
    w_wr_ok = 1'b0;
    if (flush) begin
      w_rd_ok = 1'b0;
      w_wr_ok = 1'b0;
    end else begin
      w_rd_ok = deq & ~w_empty;
      w_wr_ok = enq & (~w_full | w_rd_ok);
    end
  end

  // Next occupancy: unchanged when both or neither operation is accepted.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_W'(1'b1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state: async reset and synchronous flush both return to empty
  // and clear the sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= {PTR_W{1'b0}};
      r_tail       <= {PTR_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (flush) begin
      r_head       <= {PTR_W{1'b0}};
      r_tail       <= {PTR_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_rd_ok) begin
        r_head <= r_head + PTR_W'(1'b1);
      end
      if (w_wr_ok) begin
        r_tail <= r_tail + PTR_W'(1'b1);
      end
      r_count      <= w_count_nxt;
      r_dout_valid <= w_rd_ok;
      if (enq & w_full & ~w_rd_ok) begin
        r_overflow <= 1'b1;
      end
      if (deq & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (r_tail),
    .i_wr_data (din),
    .i_rd_en   (w_rd_ok),
    .i_rd_addr (r_head),
    .o_rd_data (w_rd_data)
  );

  // The read register is not reset, so the registered valid masks it to
  // zero whenever no word was dequeued (including during reset).
  assign dout         = w_rd_data & {DATA_W{r_dout_valid}};
  assign dout_valid   = r_dout_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Directed scoreboard bench for param_fifo (DATA_W=8, DEPTH=8, AF=6, AE=2).
module tb_param_fifo;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       enq;
  logic [7:0] din;
  logic       deq;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl_q[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] last_dout = 8'h00;

  param_fifo #(
    .DATA_W   (8),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .enq          (enq),
    .din          (din),
    .deq          (deq),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_flags();
    int n;
    n = mdl_q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == 8));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  // One clock cycle: drive at negedge, update model, check after the edge.
  task automatic step(input logic e, input logic [7:0] d, input logic q, input logic f);
    logic       rd_ok;
    logic       wr_ok;
    logic [7:0] w;
    @(negedge clk);
    enq = e; din = d; deq = q; flush = f;
    rd_ok = q && (mdl_q.size() != 0) && !f;
    wr_ok = e && ((mdl_q.size() < 8) || rd_ok) && !f;
    if (f) begin
      mdl_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (q && (mdl_q.size() == 0)) m_udf = 1'b1;
      if (e && (mdl_q.size() == 8) && !rd_ok) m_ovf = 1'b1;
      if (rd_ok) exp_q.push_back(mdl_q.pop_front());
      if (wr_ok) mdl_q.push_back(d);
    end
    @(posedge clk);
    #1;
    if (rd_ok) begin
      w = exp_q.pop_front();
      chk("dout_valid", 32'(dout_valid), 32'd1);
      chk("dout", 32'(dout), 32'(w));
      last_dout = dout;
    end else begin
      chk("dout_valid_idle", 32'(dout_valid), 32'd0);
      chk("dout_idle", 32'(dout), 32'd0);
    end
    chk_flags();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq = 1'b0; deq = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk_flags();
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, almost_full from 6 entries on.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_af", 32'(almost_full), 32'(i >= 6));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_count_after_ovf", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fill_order", 32'(last_dout), 32'(i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_order", 32'(last_dout), 32'(8'h10 + i));
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous enq/deq at full and at empty.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("sim_full_oldest", 32'(last_dout), 32'h30);
    chk("sim_full_count", 32'(count), 32'd8);
    chk("sim_full_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sim_full_last", 32'(last_dout), 32'hAA);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("sim_empty_count", 32'(count), 32'd1);
    chk("sim_empty_valid", 32'(dout_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sim_empty_word", 32'(last_dout), 32'h55);

    // Underflow, then cleared by flush.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(underflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_cleared", 32'(underflow), 32'd0);

    // Flush with 5 entries and a concurrent write.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_discard_udf", 32'(underflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Async reset between edges during a burst.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h64, 1'b1, 1'b0);
    @(negedge clk);
    enq = 1'b1; din = 8'h65; deq = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    mdl_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk("arst_dout_valid", 32'(dout_valid), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk_flags();
    @(negedge clk);
    enq = 1'b0; deq = 1'b0; rst = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("arst_post_udf", 32'(underflow), 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in entries.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port enq  input  1  write request.
REQ-009 SHALL have port din  input  DATA_W  write data.
REQ-010 SHALL have port deq  input  1  read request.
REQ-011 SHALL have port dout  output  DATA_W  registered read data.
REQ-012 SHALL have port dout_valid  output  1  dout holds a dequeued word this cycle.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write when enq=1 and (full=0 or deq is accepted in the same cycle); din stored at tail, tail advances mod DEPTH.
REQ-017 SHALL accept a read when deq=1 and empty=0; mem[head] appears on dout with dout_valid=1 on the next cycle (latency 1), head advances mod DEPTH.
REQ-018 SHALL drive dout=0 and dout_valid=0 in any cycle following a non-accepted read.
REQ-019 SHALL, on simultaneous accepted write and read, keep count unchanged; when full, read returns the oldest word and write fills the freed slot.
REQ-020 SHALL, on enq=1 and deq=1 while empty, accept the write only (no fall-through); dout_valid=0 next cycle.
REQ-021 SHALL derive full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL), all combinational from registered count.
REQ-022 SHALL set overflow on enq=1 while full=1 with no accepted read, and underflow on deq=1 while empty=1; both stay set until rst or flush; rejected operations leave pointers, count, contents unchanged.
REQ-023 SHALL, on flush=1, set head=tail=0, count=0, clear overflow/underflow, dout=0, dout_valid=0 next cycle, ignoring enq/deq that cycle.
REQ-024 SHALL wrap pointers from DEPTH-1 to 0 with no lost or duplicated entries.

Reset
REQ-025 SHALL, while rst=1, immediately force head=0, tail=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0 (hence empty=1, almost_empty=1, full=0, almost_full=0).
REQ-026 SHALL not reset storage contents; reset mid-operation discards all entries.
REQ-027 SHALL resume normal operation on the first rising edge after rst deasserts.

Structure
REQ-028 SHALL place default DATA_W/DEPTH constants and a pointer-width helper (clog2) in shared package fifo_pkg.
REQ-029 SHALL implement storage as sub-module fifo_mem (1 write port, 1 registered read port, no reset); control, pointers, count and flags stay in param_fifo.
REQ-030 SHALL elaborate-time check DEPTH power of two and AE_LEVEL<AF_LEVEL<=DEPTH.

Verification (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-031 SHALL test fill: 8 writes 0x01..0x08 -> full=1 and count=8; almost_full=1 from count=6; 9th write sets overflow and is dropped; 8 reads return 0x01..0x08 in order, each 1 cycle after deq.
REQ-032 SHALL test wrap: write 5, read 5, write 8 (0x10..0x17), read 8 -> data 0x10..0x17 in order, empty=1 at end.
REQ-033 SHALL test simultaneous: at full, enq=deq=1 with din=0xAA -> oldest word out, count stays 8, 0xAA read last; at empty, enq=deq=1 -> count=1, dout_valid=0.
REQ-034 SHALL test underflow: deq on empty -> underflow=1, dout=0, dout_valid=0, count=0; cleared by flush.
REQ-035 SHALL test flush with count=5 and enq=1 -> count=0, empty=1, written word discarded.
REQ-036 SHALL test async reset asserted mid-burst, between clock edges -> outputs at reset values before next edge; post-reset reads flag underflow.
